rangefinder_sample_capture_ctrl: RTL and testbench

//   Sequences sample capture into the 256x8 dual-port sample RAM through its write-only capture port.

---
 rtl/rangefinder_sample_capture_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_rangefinder_sample_capture_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rangefinder_sample_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rangefinder_sample_capture_ctrl
// Description : Writes the sample stream into a circular sample RAM, keeps
//               pretrig_len pre-trigger samples and closes the record once the
//               rest of the RAM holds post-trigger samples. The optional
//               forced-trigger timer is enabled by RANGEFINDER_CAPTURE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rangefinder_sample_capture_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic              trigger,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] start_addr,
    output logic              timed_out
);

    localparam logic [ADDR_W:0]   c_depth   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_one_ext = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_one     = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_pre_cnt;
    logic [ADDR_W-1:0] r_plen;
    logic [ADDR_W:0]   r_post_cnt;
    logic [ADDR_W-1:0] r_ram_address;
    logic [DATA_W-1:0] r_ram_writedata;
    logic              r_ram_write;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_start_addr;
    logic              r_timed_out;

    logic              w_active;
    logic              w_accept;
    logic              w_timeout;
    logic              w_fire;
    logic [ADDR_W:0]   w_post_init;
    logic [ADDR_W:0]   w_pre_next;

    assign w_active    = (r_state == S_PRE) || (r_state == S_WAIT_TRIG) || (r_state == S_POST);
    assign w_accept    = w_active && sample_valid && !abort;
    assign w_fire      = (r_state == S_WAIT_TRIG) && (trigger || w_timeout);
    assign w_post_init = c_depth - {1'b0, r_plen};
    assign w_pre_next  = {1'b0, r_pre_cnt} + c_one_ext;

`ifdef RANGEFINDER_CAPTURE_TIMEOUT_EN
    logic [15:0] r_timer;

    // Held at zero outside WAIT_TRIG, so it restarts on every entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_timer <= 16'd0;
        end else if (r_state != S_WAIT_TRIG) begin
            r_timer <= 16'd0;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end

    assign w_timeout = (r_timer == 16'(TIMEOUT_CYC - 1)) && !trigger;
`else
    assign w_timeout = 1'b0 & (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_wr_ptr        <= '0;
            r_pre_cnt       <= '0;
            r_plen          <= '0;
            r_post_cnt      <= '0;
            r_ram_address   <= '0;
            r_ram_writedata <= '0;
            r_ram_write     <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_start_addr    <= '0;
            r_timed_out     <= 1'b0;
        end else begin
            r_ram_write <= w_accept;
            if (w_accept) begin
                r_ram_address   <= r_wr_ptr;
                r_ram_writedata <= sample_data;
                r_wr_ptr        <= r_wr_ptr + c_one;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (arm) begin
                        r_plen      <= pretrig_len;
                        r_wr_ptr    <= '0;
                        r_pre_cnt   <= '0;
                        r_done      <= 1'b0;
                        r_timed_out <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (pretrig_len == '0) ? S_WAIT_TRIG : S_PRE;
                    end
                end

                S_PRE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_accept) begin
                        r_pre_cnt <= r_pre_cnt + c_one;
                        if (w_pre_next == {1'b0, r_plen}) begin
                            r_state <= S_WAIT_TRIG;
                        end
                    end
                end

                S_WAIT_TRIG: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_fire) begin
                        r_start_addr <= r_wr_ptr - r_plen;
                        r_timed_out  <= w_timeout;
                        // A sample arriving with the trigger is already post-trigger.
                        if (w_accept) begin
                            r_post_cnt <= w_post_init - c_one_ext;
                            if (w_post_init == c_one_ext) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_POST;
                            end
                        end else begin
                            r_post_cnt <= w_post_init;
                            r_state    <= S_POST;
                        end
                    end
                end

                S_POST: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_accept) begin
                        r_post_cnt <= r_post_cnt - c_one_ext;
                        if (r_post_cnt == c_one_ext) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_address    = r_ram_address;
    assign ram_chipselect = r_ram_write;
    assign ram_write      = r_ram_write;
    assign ram_writedata  = r_ram_writedata;
    assign busy           = r_busy;
    assign done           = r_done;
    assign start_addr     = r_start_addr;
    assign timed_out      = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_rangefinder_sample_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rangefinder_sample_capture_ctrl
// Description : Vector table, directed capture sequences and random stimulus
//               against a count-based record model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rangefinder_sample_capture_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 256;
`ifdef RANGEFINDER_CAPTURE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYC = 100;

    logic          clk = 1'b0;
    logic          reset_n, arm, abort, trigger, sample_valid;
    logic [AW-1:0] pretrig_len;
    logic [DW-1:0] sample_data;
    logic [AW-1:0] ram_address, start_addr;
    logic [DW-1:0] ram_writedata;
    logic          ram_chipselect, ram_write, busy, done, timed_out;

    always #5 clk = ~clk;

    rangefinder_sample_capture_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO_CYC)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
        .pretrig_len(pretrig_len), .trigger(trigger),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_writedata(ram_writedata),
        .busy(busy), .done(done), .start_addr(start_addr), .timed_out(timed_out)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Record model: phase is derived from accept counts since arm.
    bit            m_busy, m_done, m_to;
    int            m_plen, m_nacc, m_trig_at, m_post, m_wait;
    logic [AW-1:0] m_start;
    bit            e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        bit waiting, tmo;
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_to = 0; m_plen = 0; m_nacc = 0;
            m_trig_at = -1; m_post = 0; m_wait = 0; m_start = '0;
            e_we = 0; e_addr = '0; e_data = '0;
        end else begin
            e_we = 0;
            if (m_busy) begin
                if (abort) begin
                    m_busy = 0;
                end else begin
                    waiting = (m_trig_at < 0) && (m_nacc >= m_plen);
                    tmo     = TO_EN && waiting && !trigger && (m_wait == TO_CYC - 1);
                    if (waiting && (trigger || tmo)) begin
                        m_trig_at = m_nacc;
                        m_start   = AW'((m_nacc - m_plen) % DEPTH);
                        if (tmo) m_to = 1;
                    end
                    if (sample_valid) begin
                        e_we   = 1;
                        e_addr = AW'(m_nacc % DEPTH);
                        e_data = sample_data;
                        m_nacc++;
                        if (m_trig_at >= 0) m_post++;
                    end
                    if (m_trig_at >= 0 && m_post == DEPTH - m_plen) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                    if (m_trig_at < 0 && m_nacc >= m_plen) begin
                        if (waiting) m_wait++;
                        else         m_wait = 0;
                    end
                end
            end else if (arm && !abort) begin
                m_busy = 1; m_done = 0; m_to = 0; m_plen = int'(pretrig_len);
                m_nacc = 0; m_trig_at = -1; m_post = 0; m_wait = 0;
            end
        end
    endtask

    task automatic step();
        logic [28:0] act, exp;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        act = {busy, done, timed_out, ram_chipselect, ram_write, start_addr,
               e_we ? ram_address : 8'h00, e_we ? ram_writedata : 8'h00};
        exp = {m_busy, m_done, m_to, e_we, e_we, m_start,
               e_we ? e_addr : 8'h00, e_we ? e_data : 8'h00};
        chk("model", 64'(act), 64'(exp));
    endtask

    typedef struct {
        logic          rst_n, arm, abort;
        logic [AW-1:0] plen;
        logic          trig, valid;
        logic [DW-1:0] data;
        logic          e_busy, e_done, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [AW-1:0] e_start;
    } vec_t;

    function automatic vec_t mk(input int r, input int a, input int ab, input int pl,
                                input int tr, input int v, input int d, input int eb,
                                input int ed, input int ew, input int ea, input int edt,
                                input int es);
        vec_t x;
        x.rst_n = r[0]; x.arm = a[0]; x.abort = ab[0]; x.plen = AW'(pl);
        x.trig = tr[0]; x.valid = v[0]; x.data = DW'(d);
        x.e_busy = eb[0]; x.e_done = ed[0]; x.e_we = ew[0];
        x.e_addr = AW'(ea); x.e_data = DW'(edt); x.e_start = AW'(es);
        return x;
    endfunction

    task automatic set_idle_inputs();
        reset_n = 1; arm = 0; abort = 0; trigger = 0; sample_valid = 0;
        pretrig_len = '0; sample_data = '0;
    endtask

    task automatic do_reset();
        set_idle_inputs();
        reset_n = 0;
        step();
        reset_n = 1;
    endtask

    task automatic run_capture(input int plen, input int trig_after, input int exp_start,
                               input int exp_strobes, input string name);
        int  k, strobes;
        bit  seen_done, done_with_strobe;
        do_reset();
        arm = 1; pretrig_len = AW'(plen);
        step();
        arm = 0;
        k = 0; strobes = 0; seen_done = 0; done_with_strobe = 0;
        for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
            sample_valid = 1;
            sample_data  = DW'($urandom);
            trigger      = (k == trig_after);
            step();
            k++;
            if (ram_write) strobes++;
            if (done) begin
                seen_done        = 1;
                done_with_strobe = ram_write;
            end
        end
        trigger = 0;
        step();
        if (ram_write) strobes++;
        sample_valid = 0;
        chk({name, "_strobes"}, 64'(strobes), 64'(exp_strobes));
        chk({name, "_start"}, 64'(start_addr), 64'(exp_start));
        chk({name, "_done_with_last"}, 64'(done_with_strobe), 64'd1);
        chk({name, "_done_sticky"}, 64'({done, busy}), 64'b10);
    endtask

    vec_t tbl[13];

    initial begin
        int strobes, cyc;
        logic [28:0] act, exp;

        set_idle_inputs();
        reset_n = 0;
        step();
        step();

        // Vector table: PRE with ignored trigger, trigger with sample, abort, arm+abort, pretrig 0.
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        tbl[1]  = mk(1, 1, 0, 2, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 1, 8'hA1, 1, 0, 1, 0, 8'hA1, 0);
        tbl[3]  = mk(1, 0, 0, 0, 1, 1, 8'hA2, 1, 0, 1, 1, 8'hA2, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 1, 8'hA3, 1, 0, 1, 2, 8'hA3, 0);
        tbl[5]  = mk(1, 0, 0, 0, 1, 1, 8'hA4, 1, 0, 1, 3, 8'hA4, 1);
        tbl[6]  = mk(1, 0, 1, 0, 0, 1, 8'hC5, 0, 0, 0, 0, 8'h00, 1);
        tbl[7]  = mk(1, 1, 1, 5, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1);
        tbl[8]  = mk(1, 1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 1, 8'hB0, 1, 0, 1, 0, 8'hB0, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 8'hB1, 1, 0, 1, 1, 8'hB1, 1);
        tbl[11] = mk(1, 0, 0, 0, 1, 1, 8'hB2, 1, 0, 1, 2, 8'hB2, 2);
        tbl[12] = mk(1, 0, 1, 0, 0, 1, 8'h77, 0, 0, 0, 0, 8'h00, 2);
        for (int i = 0; i < 13; i++) begin
            reset_n = tbl[i].rst_n; arm = tbl[i].arm; abort = tbl[i].abort;
            pretrig_len = tbl[i].plen; trigger = tbl[i].trig;
            sample_valid = tbl[i].valid; sample_data = tbl[i].data;
            step();
            act = {busy, done, timed_out, ram_chipselect, ram_write, start_addr,
                   tbl[i].e_we ? ram_address : 8'h00, tbl[i].e_we ? ram_writedata : 8'h00};
            exp = {tbl[i].e_busy, tbl[i].e_done, 1'b0, tbl[i].e_we, tbl[i].e_we, tbl[i].e_start,
                   tbl[i].e_addr, tbl[i].e_data};
            chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
        end
        set_idle_inputs();

        // Reset with random inputs mid-activity clears everything.
        arm = 1; pretrig_len = 8'd3; step(); arm = 0;
        sample_valid = 1; sample_data = 8'h5A; step();
        for (int i = 0; i < 2; i++) begin
            reset_n = 0; arm = 1'($urandom); abort = 1'($urandom); trigger = 1'($urandom);
            sample_valid = 1'($urandom); sample_data = DW'($urandom); pretrig_len = AW'($urandom);
            step();
            chk("reset_outputs", 64'({ram_address, ram_chipselect, ram_write, ram_writedata,
                                      busy, done, start_addr, timed_out}), 64'd0);
        end
        set_idle_inputs();

        run_capture(16, 40, 24, 280, "pre16");
        run_capture(0, 0, 0, 256, "pre0");
`ifdef RANGEFINDER_CAPTURE_TIMEOUT_EN
        run_capture(200, 250, 50, 306, "pre200");
`else
        run_capture(200, 300, 100, 356, "pre200");
`endif

        // Abort during POST, then arm+abort together.
        do_reset();
        arm = 1; pretrig_len = 8'd4; step(); arm = 0;
        sample_valid = 1;
        for (int i = 0; i < 7; i++) begin
            sample_data = DW'($urandom);
            trigger = (i == 4);
            step();
        end
        trigger = 0; abort = 1; sample_data = 8'hEE;
        step();
        abort = 0;
        chk("abort_state", 64'({busy, done, ram_write}), 64'b000);
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ram_write) strobes++;
        end
        chk("abort_no_strobes", 64'(strobes), 64'd0);
        sample_valid = 0; arm = 1; abort = 1; step();
        chk("arm_abort_idle", 64'(busy), 64'd0);
        abort = 0; step(); arm = 0;
        chk("rearm_busy", 64'(busy), 64'd1);

        // Waiting for a trigger that never comes.
        do_reset();
        arm = 1; pretrig_len = 8'd0; step(); arm = 0;
        cyc = 0;
        while (!timed_out && cyc < 150) begin
            step();
            cyc++;
        end
`ifdef RANGEFINDER_CAPTURE_TIMEOUT_EN
        chk("timeout_cycles", 64'(cyc), 64'd100);
        chk("timeout_start", 64'(start_addr), 64'd0);
        sample_valid = 1;
        for (int i = 0; i < 400 && !done; i++) begin
            sample_data = DW'($urandom);
            step();
        end
        chk("timeout_done", 64'({done, timed_out}), 64'b11);
`else
        chk("no_timeout", 64'({busy, timed_out}), 64'b10);
`endif
        set_idle_inputs();

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset_n      = ($urandom_range(0, 799) != 0);
            arm          = ($urandom_range(0, 19) == 0);
            abort        = ($urandom_range(0, 99) == 0);
            trigger      = ($urandom_range(0, 39) == 0);
            sample_valid = ($urandom_range(0, 9) < 7);
            sample_data  = DW'($urandom);
            case ($urandom_range(0, 4))
                0:       pretrig_len = 8'd0;
                1:       pretrig_len = 8'd1;
                2:       pretrig_len = 8'd255;
                default: pretrig_len = AW'($urandom);
            endcase
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
